banked_mem: RTL
===============

# banked_mem

Four-bank, word-addressed main memory that sits directly downstream of the cache controller and serves its line fills and write-backs. Each access occupies one bank for four cycles, so a stream of requests to consecutive words (banks 0,1,2,3) is accepted one per cycle. Read data returns a fixed two cycles after acceptance. A same-bank conflict raises a combinational stall, and the requester must hold the request until it clears.

## Interface
Parameters:
- BANK_BUSY, 4: cycles a bank is occupied per access, including the accept cycle; legal range 2..4.
- RD_LAT, 2: cycles from read accept to data_valid. Fixed at 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- addr  in  16  byte address. addr[2:1] selects the bank; addr[15:3] is the row within the bank; addr[0] must be 0.
- data_in  in  16  write data.
- wr  in  1  write request.
- rd  in  1  read request.
- data_out  out  16  read data; valid when data_valid=1, otherwise 16'h0000.
- data_valid  out  1  read data returning this cycle.
- stall  out  1  combinational; the request in this cycle is not accepted.
- busy  out  4  per-bank occupied flag, bit b = bank b.
- err  out  1  one-cycle pulse flagging an illegal request made in the previous cycle.

## Operation
- Storage: 4 banks × 8192 words × 16 bits, not reset. Contents after power-up are undefined.
- Each bank has a 2-bit down-counter cnt[b]; busy[b] = (cnt[b] != 0).
- A request is present when rd|wr is high.
- A request is illegal when (rd & wr) or (addr[0] & (rd|wr)).
  - An illegal request never accesses the array.
  - It never loads a counter and never stalls.
  - err=1 on the next cycle.
- stall = legal request present & busy[addr[2:1]]. A stalled request has no side effects.
- A request is accepted when it is present, legal, not stalled, and rst=1. On accept:
  - cnt[addr[2:1]] loads BANK_BUSY-1.
  - A write updates mem[bank][addr[15:3]] at the end of the accept cycle.
  - A read captures mem[bank][addr[15:3]] into a 2-stage pipeline of (valid, data).
- Counters that are nonzero decrement by 1 each cycle. A bank is free again in cycle T+BANK_BUSY.
- At most one request per cycle (single request port); requests to different free banks in consecutive cycles are each accepted.
- Read pipeline: stage1 <= {accept&rd, array data}; stage2 <= stage1. data_valid = stage2.valid; data_out = stage2.valid ? stage2.data : 0.
- Read-after-write ordering:
  - A same-address read cannot be accepted before T+BANK_BUSY, so it always returns the written data.
  - A different-bank read in any cycle is unaffected.
- Reset (rst=0 at a rising edge):
  - All cnt=0, pipeline valids=0, err=0.
  - In-flight reads are dropped.
  - A request presented in a cycle with rst=0 is neither accepted nor written.
- Reset values: data_out=0, data_valid=0, busy=4'b0000, err=0. stall=0 while rst=0.

## Timing
- Read accepted at edge T: data_valid=1 and data_out=data during cycle T+2, for exactly 1 cycle.
- Write accepted at T: the array is updated at edge T.
- busy[b] is high for cycles T+1..T+BANK_BUSY-1.
- stall is combinational from addr, rd, wr and the registered busy; there is no added latency.
- err is asserted in cycle T+1 for an illegal request at T.
- The pipeline keeps advancing during stalls.
- Back-to-back reads to banks 0,1,2,3 at T..T+3 return data at T+2..T+5 in order, which is the cadence the cache fill sequence relies on.

## Test plan
- After reset, write 16'hBEEF to 16'h0010 at cycle 0, then read 16'h0010 at cycle 4 → data_valid=1 and data_out=16'hBEEF in cycle 6; busy=4'b0001 in cycles 1-3.
- Write to 16'h0020 at cycle 0, then read 16'h0028 (same bank) at cycles 1-3 → stall=1 in cycles 1-3; read accepted in cycle 4; data at cycle 6. There must be no spurious data_valid.
- Reads to 16'h0100, 0102, 0104, 0106 on consecutive cycles (memory preloaded with 1,2,3,4) → no stall; data_out=1,2,3,4 in cycles 2-5.
- rd=wr=1 at 16'h0000, or rd=1 at 16'h0001 → err=1 the next cycle; busy unchanged; no data_valid; the array is unchanged (verified by a later read).
- Accept a read at cycle 0, then rst=0 at cycle 1 → data_valid stays 0 through cycle 3; busy=0 from cycle 2.
- A write presented with rst=0 → after reset release, a read of that address returns the prior contents.

Source files
------------

// File: rtl/banked_mem.sv
// Four-bank 16-bit word memory; reads return data_valid/data_out two cycles after accept.
// Backpressure: combinational stall while the addressed bank is busy; requester holds the request.
module banked_mem #(
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        wr,
  input  logic        rd,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam logic [1:0] CNT_LOAD = 2'(BANK_BUSY - 1);

  logic [15:0] mem [4][8192];
  logic [1:0]  cnt [4];

  logic [RD_LAT-1:0] pipe_vld;
  logic [15:0]       pipe_dat [RD_LAT];

  logic [1:0]  bank;
  logic [12:0] row;
  logic        req;
  logic        illegal;
  logic        accept;

  assign bank    = addr[2:1];
  assign row     = addr[15:3];
  assign req     = rd | wr;
  assign illegal = (rd & wr) | (addr[0] & req);

  always_comb begin
    busy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      busy[b] = (cnt[b] != 2'd0);
    end
  end

  // Illegal requests bypass the bank check entirely, and nothing stalls during reset.
  assign stall  = rst & req & ~illegal & busy[bank];
  assign accept = rst & req & ~illegal & ~busy[bank];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= 2'd0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (accept && (bank == 2'(b))) begin
          cnt[b] <= CNT_LOAD;
        end else if (cnt[b] != 2'd0) begin
          cnt[b] <= cnt[b] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= accept & rd;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  // Array and read data are not reset; the valid pipeline gates what is visible.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[bank][row] <= data_in;
    end
    pipe_dat[0] <= mem[bank][row];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  assign data_valid = pipe_vld[RD_LAT-1];
  assign data_out   = pipe_vld[RD_LAT-1] ? pipe_dat[RD_LAT-1] : 16'h0000;

endmodule
